usbdev_linestate_mon: RTL and testbench
=======================================

Name: usbdev_linestate_mon

Overview:
- Receive-side counterpart of the USB pin mux.
- Consumes the already-synchronized dp/dn/VBUS-sense signals in the usb clock domain.
- Filters glitches and classifies the bus line state.
- Times bus conditions against a 1 us tick and runs the link-state FSM (disconnect, power, bus reset, suspend, resume), producing event pulses for the device core and interrupt logic.

Parameters:
- FilterCycles, 3, consecutive identical raw samples required before line_state_o changes (1..15).
- TimerW, 12, width of the line-condition microsecond timer.
- ResetUs, 3, SE0 duration (us) that qualifies as bus reset.
- SuspendUs, 3000, continuous J duration (us) that qualifies as suspend; must be < 2^TimerW.
- VbusDebUs, 8, stable-sense duration (us) before vbus_ok_o changes.

Ports:
- clk_i  in  1  usb clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  monitor enable; low forces DISCONNECTED.
- us_tick_i  in  1  one-cycle strobe every 1 us.
- usb_rx_dp_i  in  1  synchronized D+.
- usb_rx_dn_i  in  1  synchronized D-.
- usb_pwr_sense_i  in  1  synchronized VBUS sense.
- line_state_o  out  2  filtered line state: 0 SE0, 1 J, 2 K, 3 SE1.
- link_state_o  out  3  0 DISCONNECTED, 1 POWERED, 2 ACTIVE, 3 SUSPENDED, 4 RESUMING.
- vbus_ok_o  out  1  debounced VBUS present.
- bus_reset_active_o  out  1  high while SE0 has lasted >= ResetUs.
- evt_bus_reset_o  out  1  one-cycle pulse.
- evt_suspend_o  out  1  one-cycle pulse.
- evt_resume_o  out  1  one-cycle pulse.
- evt_disconnect_o  out  1  one-cycle pulse.

Behaviour:
- Reset values: line_state_o=SE0 (0), link_state_o=DISCONNECTED, vbus_ok_o=0, all other outputs 0.
- rst_i asserted mid-operation clears every register on that edge. No event pulse is generated because of reset.
- Raw line state is {dp,dn}: 00→SE0, 10→J, 01→K, 11→SE1.
- Filter: holds a candidate value and a 4-bit counter.
  - A raw change reloads the candidate and clears the counter.
  - line_state_o takes the candidate on the edge at which the candidate has been sampled FilterCycles consecutive times.
  - A step on the pins becomes visible on line_state_o exactly FilterCycles cycles later.
  - Pulses shorter than FilterCycles cycles never appear.
- Line timer:
  - Cleared whenever line_state_o changes.
  - Otherwise incremented on us_tick_i; saturates at all-ones.
- VBUS debounce: separate counter, cleared when usb_pwr_sense_i differs from vbus_ok_o. vbus_ok_o toggles when the counter reaches VbusDebUs ticks.
- bus_reset_active_o = (line_state_o==SE0) && timer>=ResetUs && link_state_o!=DISCONNECTED.
- FSM priorities, evaluated each cycle:
  - Highest: (!enable_i || !vbus_ok_o) → DISCONNECTED. evt_disconnect_o pulses if the previous state was not DISCONNECTED.
  - DISCONNECTED → POWERED when enable_i && vbus_ok_o.
  - POWERED, ACTIVE, SUSPENDED, RESUMING → ACTIVE with evt_bus_reset_o pulse on the tick where the SE0 timer reaches exactly ResetUs. One pulse per SE0 episode. Bus reset outranks suspend and resume.
  - ACTIVE → SUSPENDED with evt_suspend_o on the tick where the J timer reaches exactly SuspendUs.
  - SUSPENDED → RESUMING when line_state_o becomes K.
  - RESUMING → ACTIVE with evt_resume_o when line_state_o leaves K to SE0 or J.
- SE1 is never an accepted idle. It clears the timer like any other state change and causes no transition.
- Timer saturation must not re-trigger events.

Optional Feature:
- Macro: USBDEV_LINESTATE_SE1_ERR_EN.
- When defined:
  - Adds output se1_err_cnt_o (8 bits) and input se1_err_clr_i (1 bit).
  - The counter increments once per entry of line_state_o into SE1 and saturates at 255.
  - The clear wins over a simultaneous increment.
  - Reset value is 0.
- When undefined: both ports and the counter are absent; all other behaviour is identical.

Decomposition:
- usbdev_pkg gains line_state_e (2-bit) and link_state_e (3-bit) enums plus default timing constants (ResetUs, SuspendUs, VbusDebUs).
- One sub-module, usbdev_linestate_filter: parameterized-width stable-sample filter.
  - Used for the dp/dn pair with FilterCycles.
  - Reusable for the sense input.

Test Plan:
- Reset, enable=1, sense=1 held, 8 ticks → vbus_ok_o=1 at tick 8; link POWERED next cycle; all events 0.
- In POWERED, drive SE0 for 3 ticks → evt_bus_reset_o single pulse at tick 3; link ACTIVE. Holding SE0 to 10 ticks gives no further pulse; bus_reset_active_o stays 1.
- In ACTIVE, J for 3000 ticks → evt_suspend_o at tick 3000; link SUSPENDED. Then K → RESUMING after FilterCycles=3 cycles; then J → evt_resume_o, ACTIVE.
- Glitch: a 2-cycle K pulse within J → line_state_o stays J and the J timer is unaffected. A 3-cycle K → line_state_o=K exactly 3 cycles after the step.
- Drop sense while SUSPENDED for 8 ticks → evt_disconnect_o one pulse, link DISCONNECTED. Deassert enable_i in ACTIVE → same, same cycle. Assert rst_i mid-SE0 → all outputs to reset values with no pulse.
- With USBDEV_LINESTATE_SE1_ERR_EN: 300 SE1 entries → count 255. se1_err_clr_i coincident with an SE1 entry → count 0.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared USB device types: bus line-state and link-state encodings plus default
// timing constants used by the line-state monitor.
package usbdev_pkg;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'd0,
        LINE_J   = 2'd1,
        LINE_K   = 2'd2,
        LINE_SE1 = 2'd3
    } line_state_e;

    typedef enum logic [2:0] {
        LINK_DISCONNECTED = 3'd0,
        LINK_POWERED      = 3'd1,
        LINK_ACTIVE       = 3'd2,
        LINK_SUSPENDED    = 3'd3,
        LINK_RESUMING     = 3'd4
    } link_state_e;

    localparam int unsigned ResetUsDefault   = 3;
    localparam int unsigned SuspendUsDefault = 3000;
    localparam int unsigned VbusDebUsDefault = 8;

    // Full-speed pin pair {dp,dn} to bus line state.
    function automatic line_state_e decode_line(input logic dp, input logic dn);
        line_state_e line;
        case ({dp, dn})
            2'b10:   line = LINE_J;
            2'b01:   line = LINE_K;
            2'b11:   line = LINE_SE1;
            default: line = LINE_SE0;
        endcase
        return line;
    endfunction

endpackage

// File: rtl/usbdev_linestate_filter.sv
// Stable-sample filter: the output takes a new value only after the input has
// held it for Cycles consecutive clock samples. o_next is the value loaded next edge.
module usbdev_linestate_filter #(
    parameter int unsigned Width  = 2,
    parameter int unsigned Cycles = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] i_raw,
    output logic [Width-1:0] o_stable,
    output logic [Width-1:0] o_next
);

    logic [Width-1:0] r_cand;
    logic [Width-1:0] r_stable;
    logic [3:0]       r_count;
    logic [4:0]       w_count;

    // Number of consecutive samples of the current raw value, including this one.
    assign w_count  = (i_raw == r_cand) ? ({1'b0, r_count} + 5'd1) : 5'd1;
    assign o_next   = (w_count >= 5'(Cycles)) ? i_raw : r_stable;
    assign o_stable = r_stable;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cand   <= '0;
            r_count  <= '0;
            r_stable <= '0;
        end else begin
            r_cand   <= i_raw;
            r_count  <= (w_count > 5'd15) ? 4'hF : w_count[3:0];
            r_stable <= o_next;
        end
    end

endmodule

// File: rtl/usbdev_linestate_mon.sv
// USB receive line-state monitor: glitch filter, us line timer, VBUS debounce and
// link-state FSM. Define USBDEV_LINESTATE_SE1_ERR_EN to add the SE1 error counter.
module usbdev_linestate_mon
    import usbdev_pkg::*;
#(
    parameter int unsigned FilterCycles = 3,
    parameter int unsigned TimerW       = 12,
    parameter int unsigned ResetUs      = ResetUsDefault,
    parameter int unsigned SuspendUs    = SuspendUsDefault,
    parameter int unsigned VbusDebUs    = VbusDebUsDefault
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       us_tick_i,
    input  logic       usb_rx_dp_i,
    input  logic       usb_rx_dn_i,
    input  logic       usb_pwr_sense_i,
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
    input  logic       se1_err_clr_i,
    output logic [7:0] se1_err_cnt_o,
`endif
    output logic [1:0] line_state_o,
    output logic [2:0] link_state_o,
    output logic       vbus_ok_o,
    output logic       bus_reset_active_o,
    output logic       evt_bus_reset_o,
    output logic       evt_suspend_o,
    output logic       evt_resume_o,
    output logic       evt_disconnect_o
);

    localparam int unsigned VbusW = $clog2(VbusDebUs + 1);

    logic [1:0]        w_raw_line;
    logic [1:0]        w_line;
    logic [1:0]        w_line_next;
    logic              w_line_change;
    logic [TimerW-1:0] r_timer;
    logic              w_timer_inc;
    logic              w_reset_hit;
    logic              w_suspend_hit;
    logic [VbusW-1:0]  r_vbus_cnt;
    logic              r_vbus_ok;
    link_state_e       r_link_state;
    link_state_e       w_link_next;
    logic              w_evt_bus_reset;
    logic              w_evt_suspend;
    logic              w_evt_resume;
    logic              w_evt_disconnect;
    logic              r_evt_bus_reset;
    logic              r_evt_suspend;
    logic              r_evt_resume;
    logic              r_evt_disconnect;

    assign w_raw_line = decode_line(usb_rx_dp_i, usb_rx_dn_i);

    usbdev_linestate_filter #(
        .Width  (2),
        .Cycles (FilterCycles)
    ) u_line_filter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_raw    (w_raw_line),
        .o_stable (w_line),
        .o_next   (w_line_next)
    );

    assign w_line_change = (w_line_next != w_line);

    // Events fire only on the increment that lands exactly on the threshold, so a
    // saturated or held timer can never retrigger them.
    assign w_timer_inc   = us_tick_i && !w_line_change && (r_timer != '1);
    assign w_reset_hit   = w_timer_inc && (w_line == LINE_SE0) &&
                           (r_timer == TimerW'(ResetUs - 1));
    assign w_suspend_hit = w_timer_inc && (w_line == LINE_J) &&
                           (r_timer == TimerW'(SuspendUs - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (w_line_change) begin
            r_timer <= '0;
        end else if (w_timer_inc) begin
            r_timer <= r_timer + TimerW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vbus_cnt <= '0;
            r_vbus_ok  <= 1'b0;
        end else if (usb_pwr_sense_i == r_vbus_ok) begin
            r_vbus_cnt <= '0;
        end else if (us_tick_i) begin
            if (r_vbus_cnt == VbusW'(VbusDebUs - 1)) begin
                r_vbus_ok  <= usb_pwr_sense_i;
                r_vbus_cnt <= '0;
            end else begin
                r_vbus_cnt <= r_vbus_cnt + VbusW'(1);
            end
        end
    end

    always_comb begin
        w_link_next      = r_link_state;
        w_evt_bus_reset  = 1'b0;
        w_evt_suspend    = 1'b0;
        w_evt_resume     = 1'b0;
        w_evt_disconnect = 1'b0;
        if (!enable_i || !r_vbus_ok) begin
            w_link_next      = LINK_DISCONNECTED;
            w_evt_disconnect = (r_link_state != LINK_DISCONNECTED);
        end else if (r_link_state == LINK_DISCONNECTED) begin
            w_link_next = LINK_POWERED;
        end else if (w_reset_hit) begin
            w_link_next     = LINK_ACTIVE;
            w_evt_bus_reset = 1'b1;
        end else begin
            case (r_link_state)
                LINK_ACTIVE: begin
                    if (w_suspend_hit) begin
                        w_link_next   = LINK_SUSPENDED;
                        w_evt_suspend = 1'b1;
                    end
                end
                LINK_SUSPENDED: begin
                    if (w_line_change && (w_line_next == LINE_K)) begin
                        w_link_next = LINK_RESUMING;
                    end
                end
                LINK_RESUMING: begin
                    if (w_line_change &&
                        ((w_line_next == LINE_SE0) || (w_line_next == LINE_J))) begin
                        w_link_next  = LINK_ACTIVE;
                        w_evt_resume = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_link_state     <= LINK_DISCONNECTED;
            r_evt_bus_reset  <= 1'b0;
            r_evt_suspend    <= 1'b0;
            r_evt_resume     <= 1'b0;
            r_evt_disconnect <= 1'b0;
        end else begin
            r_link_state     <= w_link_next;
            r_evt_bus_reset  <= w_evt_bus_reset;
            r_evt_suspend    <= w_evt_suspend;
            r_evt_resume     <= w_evt_resume;
            r_evt_disconnect <= w_evt_disconnect;
        end
    end

`ifdef USBDEV_LINESTATE_SE1_ERR_EN
    logic [7:0] r_se1_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || se1_err_clr_i) begin
            r_se1_err_cnt <= '0;
        end else if (w_line_change && (w_line_next == LINE_SE1) &&
                     (r_se1_err_cnt != 8'hFF)) begin
            r_se1_err_cnt <= r_se1_err_cnt + 8'd1;
        end
    end

    assign se1_err_cnt_o = r_se1_err_cnt;
`endif

    assign line_state_o       = w_line;
    assign link_state_o       = r_link_state;
    assign vbus_ok_o          = r_vbus_ok;
    assign bus_reset_active_o = (w_line == LINE_SE0) && (r_timer >= TimerW'(ResetUs)) &&
                                (r_link_state != LINK_DISCONNECTED);
    assign evt_bus_reset_o    = r_evt_bus_reset;
    assign evt_suspend_o      = r_evt_suspend;
    assign evt_resume_o       = r_evt_resume;
    assign evt_disconnect_o   = r_evt_disconnect;

endmodule

// File: tb/tb_usbdev_linestate_mon.sv
// Directed bench for usbdev_linestate_mon: a behavioural model checked every cycle
// plus hand-computed expectations at the key points of each scenario.
module tb_usbdev_linestate_mon;

    localparam int FILT    = 3;
    localparam int RST_US  = 3;
    localparam int SUSP_US = 3000;
    localparam int VDEB    = 8;
    localparam int TMAX    = 4095;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic       us_tick_i;
    logic       dp;
    logic       dn;
    logic       sense;
    logic [1:0] line_state_o;
    logic [2:0] link_state_o;
    logic       vbus_ok_o;
    logic       bus_reset_active_o;
    logic       evt_bus_reset_o;
    logic       evt_suspend_o;
    logic       evt_resume_o;
    logic       evt_disconnect_o;
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
    logic       se1_clr;
    logic [7:0] se1_cnt;
`endif

    always #5 clk = ~clk;

    usbdev_linestate_mon #(
        .FilterCycles (FILT),
        .TimerW       (12),
        .ResetUs      (RST_US),
        .SuspendUs    (SUSP_US),
        .VbusDebUs    (VDEB)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .us_tick_i          (us_tick_i),
        .usb_rx_dp_i        (dp),
        .usb_rx_dn_i        (dn),
        .usb_pwr_sense_i    (sense),
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
        .se1_err_clr_i      (se1_clr),
        .se1_err_cnt_o      (se1_cnt),
`endif
        .line_state_o       (line_state_o),
        .link_state_o       (link_state_o),
        .vbus_ok_o          (vbus_ok_o),
        .bus_reset_active_o (bus_reset_active_o),
        .evt_bus_reset_o    (evt_bus_reset_o),
        .evt_suspend_o      (evt_suspend_o),
        .evt_resume_o       (evt_resume_o),
        .evt_disconnect_o   (evt_disconnect_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_line = 0, m_link = 0, m_vbus = 0, m_ticks = 0, m_vcnt = 0, m_se1 = 0;
    int m_evt_rst = 0, m_evt_susp = 0, m_evt_res = 0, m_evt_disc = 0;
    int hist[$];

    always @(posedge clk) begin : model
        int  raw, new_line, old_ticks;
        bit  changed, same, rhit, shit;
        if (rst_i) begin
            m_line = 0; m_link = 0; m_vbus = 0; m_ticks = 0; m_vcnt = 0; m_se1 = 0;
            m_evt_rst = 0; m_evt_susp = 0; m_evt_res = 0; m_evt_disc = 0;
            hist.delete();
        end else begin
            raw = (dp && !dn) ? 1 : (!dp && dn) ? 2 : (dp && dn) ? 3 : 0;
            hist.push_back(raw);
            if (hist.size() > FILT) void'(hist.pop_front());
            new_line = m_line;
            if (hist.size() == FILT) begin
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != raw) same = 1'b0;
                if (same) new_line = raw;
            end
            changed   = (new_line != m_line);
            old_ticks = m_ticks;
            rhit = !changed && us_tick_i && m_line == 0 && old_ticks == RST_US - 1;
            shit = !changed && us_tick_i && m_line == 1 && old_ticks == SUSP_US - 1;
            m_evt_rst = 0; m_evt_susp = 0; m_evt_res = 0; m_evt_disc = 0;
            if (!enable_i || m_vbus == 0) begin
                if (m_link != 0) m_evt_disc = 1;
                m_link = 0;
            end else if (m_link == 0) begin
                m_link = 1;
            end else if (rhit) begin
                m_link = 2; m_evt_rst = 1;
            end else if (m_link == 2 && shit) begin
                m_link = 3; m_evt_susp = 1;
            end else if (m_link == 3 && changed && new_line == 2) begin
                m_link = 4;
            end else if (m_link == 4 && changed && (new_line == 0 || new_line == 1)) begin
                m_link = 2; m_evt_res = 1;
            end
            if (changed) m_ticks = 0;
            else if (us_tick_i && m_ticks < TMAX) m_ticks = m_ticks + 1;
            if (int'(sense) == m_vbus) m_vcnt = 0;
            else if (us_tick_i) begin
                m_vcnt = m_vcnt + 1;
                if (m_vcnt == VDEB) begin
                    m_vbus = int'(sense);
                    m_vcnt = 0;
                end
            end
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
            if (se1_clr) m_se1 = 0;
            else if (changed && new_line == 3 && m_se1 < 255) m_se1 = m_se1 + 1;
`endif
            m_line = new_line;
        end
    end

    always @(negedge clk) begin
        chk("line_state", int'(line_state_o), m_line);
        chk("link_state", int'(link_state_o), m_link);
        chk("vbus_ok", int'(vbus_ok_o), m_vbus);
        chk("bus_reset_active", int'(bus_reset_active_o),
            (m_line == 0 && m_ticks >= RST_US && m_link != 0) ? 1 : 0);
        chk("evt_bus_reset", int'(evt_bus_reset_o), m_evt_rst);
        chk("evt_suspend", int'(evt_suspend_o), m_evt_susp);
        chk("evt_resume", int'(evt_resume_o), m_evt_res);
        chk("evt_disconnect", int'(evt_disconnect_o), m_evt_disc);
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
        chk("se1_err_cnt", int'(se1_cnt), m_se1);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            us_tick_i = 1'b0;
            repeat (3) @(negedge clk);
            us_tick_i = 1'b1;
            @(negedge clk);
            us_tick_i = 1'b0;
        end
    endtask

    task automatic set_line(input logic p, input logic n);
        dp = p;
        dn = n;
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; us_tick_i = 1'b0; sense = 1'b0;
        set_line(1'b0, 1'b0);
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
        se1_clr = 1'b0;
`endif
        cyc(3);
        chk("rst_line", int'(line_state_o), 0);
        chk("rst_link", int'(link_state_o), 0);
        chk("rst_vbus", int'(vbus_ok_o), 0);
        rst_i = 1'b0;

        // power-up with J on the bus
        enable_i = 1'b1; sense = 1'b1; set_line(1'b1, 1'b0);
        do_ticks(7);
        chk("vbus_tick7", int'(vbus_ok_o), 0);
        do_ticks(1);
        chk("vbus_tick8", int'(vbus_ok_o), 1);
        chk("link_at_vbus", int'(link_state_o), 0);
        cyc(1);
        chk("link_powered", int'(link_state_o), 1);

        // bus reset from POWERED
        set_line(1'b0, 1'b0);
        cyc(3);
        chk("line_se0", int'(line_state_o), 0);
        do_ticks(2);
        chk("no_reset_tick2", int'(evt_bus_reset_o), 0);
        do_ticks(1);
        chk("reset_pulse", int'(evt_bus_reset_o), 1);
        chk("link_active", int'(link_state_o), 2);
        chk("bra_tick3", int'(bus_reset_active_o), 1);
        cyc(1);
        chk("reset_pulse_end", int'(evt_bus_reset_o), 0);
        do_ticks(7);
        chk("bra_tick10", int'(bus_reset_active_o), 1);

        // suspend after 3000 us of J, then resume
        set_line(1'b1, 1'b0);
        cyc(3);
        do_ticks(SUSP_US - 1);
        chk("no_susp_2999", int'(evt_suspend_o), 0);
        do_ticks(1);
        chk("susp_pulse", int'(evt_suspend_o), 1);
        chk("link_susp", int'(link_state_o), 3);
        set_line(1'b0, 1'b1);
        cyc(2);
        chk("susp_line_j", int'(line_state_o), 1);
        cyc(1);
        chk("resume_line_k", int'(line_state_o), 2);
        chk("link_resuming", int'(link_state_o), 4);
        set_line(1'b1, 1'b0);
        cyc(3);
        chk("resume_pulse", int'(evt_resume_o), 1);
        chk("link_active2", int'(link_state_o), 2);

        // 2-cycle K glitch inside J must not disturb the J timer
        do_ticks(5);
        set_line(1'b0, 1'b1);
        cyc(2);
        set_line(1'b1, 1'b0);
        do_ticks(SUSP_US - 6);
        chk("glitch_no_susp", int'(evt_suspend_o), 0);
        do_ticks(1);
        chk("glitch_susp", int'(evt_suspend_o), 1);

        // VBUS drop while suspended
        sense = 1'b0;
        do_ticks(VDEB);
        chk("vbus_drop", int'(vbus_ok_o), 0);
        cyc(1);
        chk("disc_pulse", int'(evt_disconnect_o), 1);
        chk("link_disc", int'(link_state_o), 0);
        cyc(1);
        chk("disc_pulse_end", int'(evt_disconnect_o), 0);

        // re-power, bus reset, then a full 3-cycle K and an SE1 in ACTIVE
        sense = 1'b1;
        do_ticks(VDEB);
        cyc(1);
        set_line(1'b0, 1'b0);
        cyc(3);
        do_ticks(RST_US);
        chk("link_active3", int'(link_state_o), 2);
        set_line(1'b1, 1'b0);
        cyc(3);
        set_line(1'b0, 1'b1);
        cyc(2);
        chk("k3_still_j", int'(line_state_o), 1);
        cyc(1);
        chk("k3_visible", int'(line_state_o), 2);
        set_line(1'b1, 1'b0);
        cyc(3);
        set_line(1'b1, 1'b1);
        cyc(3);
        chk("se1_line", int'(line_state_o), 3);
        chk("se1_link", int'(link_state_o), 2);
        set_line(1'b1, 1'b0);
        cyc(3);

        // enable drop in ACTIVE
        enable_i = 1'b0;
        cyc(1);
        chk("en_disc_link", int'(link_state_o), 0);
        chk("en_disc_pulse", int'(evt_disconnect_o), 1);
        enable_i = 1'b1;
        cyc(1);
        chk("en_repower", int'(link_state_o), 1);

        // reset mid-SE0 while bus reset is active
        set_line(1'b0, 1'b0);
        cyc(3);
        do_ticks(RST_US + 1);
        chk("pre_rst_bra", int'(bus_reset_active_o), 1);
        rst_i = 1'b1;
        cyc(1);
        chk("mid_rst_link", int'(link_state_o), 0);
        chk("mid_rst_bra", int'(bus_reset_active_o), 0);
        chk("mid_rst_vbus", int'(vbus_ok_o), 0);
        chk("mid_rst_disc", int'(evt_disconnect_o), 0);
        cyc(1);
        rst_i = 1'b0;

`ifdef USBDEV_LINESTATE_SE1_ERR_EN
        for (int i = 0; i < 300; i++) begin
            set_line(1'b1, 1'b1);
            cyc(3);
            set_line(1'b1, 1'b0);
            cyc(3);
        end
        chk("se1_sat", int'(se1_cnt), 255);
        set_line(1'b1, 1'b1);
        cyc(2);
        se1_clr = 1'b1;
        cyc(1);
        se1_clr = 1'b0;
        chk("se1_clr_wins", int'(se1_cnt), 0);
        set_line(1'b1, 1'b0);
        cyc(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
